memory_load_unit: RTL and testbench

Sequential load-data unit for the NPC LSU: accepts one load request at a time, issues one or two aligned bus reads, merges beats for misaligned accesses, and returns an extracted, sign- or zero-extended result. It is the parametrised successor of the combinational load-extension path. It generalises to RV32/RV64 data widths, adds doubleword and `lwu` support, splits beat-crossing accesses, and carries a bus-error response. It sits between the LSU request stage and the data-memory read bus.

---
 rtl/memory_load_unit.sv | 128 ++++++++++++
 tb/tb_memory_load_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_load_unit.sv
// Sequential load-data unit: issues one or two beat-aligned bus reads per load, merges
// beats for misaligned accesses and returns a sign/zero-extended result with error flag.
module memory_load_unit #(
    parameter int unsigned DATA_LEN = 64,
    parameter int unsigned ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_sign,
    output logic                bus_ar_valid,
    input  logic                bus_ar_ready,
    output logic [ADDR_LEN-1:0] bus_ar_addr,
    input  logic                bus_r_valid,
    output logic                bus_r_ready,
    input  logic [DATA_LEN-1:0] bus_r_data,
    input  logic                bus_r_err,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_err
);

    localparam int unsigned BYTES = DATA_LEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {StIdle, StAr0, StR0, StAr1, StR1, StResp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [DATA_LEN-1:0]   beat0_q;

    logic [OFF_W-1:0]      off;
    logic [OFF_W+1:0]      span;
    logic                  split;
    logic                  illegal;
    logic [ADDR_LEN-1:0]   base_addr;
    logic [2*DATA_LEN-1:0] merged;
    logic [DATA_LEN-1:0]   raw, mask, ext;
    logic                  msb;
    int unsigned           width;

    always_comb begin
        off       = addr_q[OFF_W-1:0];
        span      = (OFF_W+2)'(off) + ((OFF_W+2)'(1) << size_q);
        split     = span > (OFF_W+2)'(BYTES);
        illegal   = (DATA_LEN == 32) && (req_size == 2'b11);
        base_addr = addr_q & ~ADDR_LEN'(BYTES - 1);
        bus_ar_addr = (state_q == StAr1) ? base_addr + ADDR_LEN'(BYTES) : base_addr;

        // Second beat only exists in R1; a single-beat access merges against zero.
        merged = (state_q == StR1) ? {bus_r_data, beat0_q} : {{DATA_LEN{1'b0}}, bus_r_data};
        raw    = DATA_LEN'(merged >> {off, 3'b000});

        width = 32'd8 << size_q;
        mask  = '1;
        msb   = 1'b0;
        ext   = raw;
        if (width < DATA_LEN) begin
            mask = ~({DATA_LEN{1'b1}} << width);
            msb  = |(raw & (DATA_LEN'(1) << (width - 1)));
            ext  = (raw & mask) | ((sign_q && msb) ? ~mask : '0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid) state_d = illegal ? StResp : StAr0;
            StAr0:   if (bus_ar_ready) state_d = StR0;
            StR0:    if (bus_r_valid) state_d = (bus_r_err || !split) ? StResp : StAr1;
            StAr1:   if (bus_ar_ready) state_d = StR1;
            StR1:    if (bus_r_valid) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_ready    <= 1'b1;
            bus_ar_valid <= 1'b0;
            bus_r_ready  <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready    <= (state_d == StIdle);
            bus_ar_valid <= (state_d == StAr0) || (state_d == StAr1);
            bus_r_ready  <= (state_d == StR0) || (state_d == StR1);
            resp_valid   <= (state_d == StResp);

            if (state_q == StIdle && req_valid) begin
                addr_q <= req_addr;
                size_q <= req_size;
                sign_q <= req_sign;
                if (illegal) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
            end

            if (state_q == StR0 && bus_r_valid) begin
                beat0_q <= bus_r_data;
                if (bus_r_err) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end else if (!split) begin
                    resp_data <= ext;
                    resp_err  <= 1'b0;
                end
            end

            if (state_q == StR1 && bus_r_valid) begin
                resp_data <= bus_r_err ? '0 : ext;
                resp_err  <= bus_r_err;
            end
        end
    end

endmodule

// File: tb/tb_memory_load_unit.sv
// Self-checking bench for memory_load_unit: table of loads against a small memory model,
// plus backpressure, mid-transaction reset and RV32 illegal-size sequences.
module tb_memory_load_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        req_valid, req_ready, req_sign;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        bus_ar_valid, bus_ar_ready, bus_r_valid, bus_r_ready, bus_r_err;
    logic [31:0] bus_ar_addr;
    logic [63:0] bus_r_data;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_data;

    logic        req_valid32, req_ready32, req_sign32;
    logic [31:0] req_addr32;
    logic [1:0]  req_size32;
    logic        bus_ar_valid32, bus_r_ready32;
    logic        bus_ar_ready32 = 1'b0;
    logic        bus_r_valid32 = 1'b0;
    logic        bus_r_err32 = 1'b0;
    logic [31:0] bus_ar_addr32;
    logic [31:0] bus_r_data32 = '0;
    logic        resp_valid32, resp_ready32, resp_err32;
    logic [31:0] resp_data32;

    memory_load_unit #(.DATA_LEN(64), .ADDR_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sign(req_sign),
        .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready), .bus_ar_addr(bus_ar_addr),
        .bus_r_valid(bus_r_valid), .bus_r_ready(bus_r_ready), .bus_r_data(bus_r_data),
        .bus_r_err(bus_r_err),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err)
    );

    memory_load_unit #(.DATA_LEN(32), .ADDR_LEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr32),
        .req_size(req_size32), .req_sign(req_sign32),
        .bus_ar_valid(bus_ar_valid32), .bus_ar_ready(bus_ar_ready32),
        .bus_ar_addr(bus_ar_addr32),
        .bus_r_valid(bus_r_valid32), .bus_r_ready(bus_r_ready32), .bus_r_data(bus_r_data32),
        .bus_r_err(bus_r_err32),
        .resp_valid(resp_valid32), .resp_ready(resp_ready32), .resp_data(resp_data32),
        .resp_err(resp_err32)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic        err_en;
        logic [31:0] err_addr;
        logic [63:0] data;
        logic        err;
        int          lat;
        int          nar;
        logic [31:0] ar0;
        logic [31:0] ar1;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] pend[$];
    vec_t        vecs[$];

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;
    int ar_wait = 0, r_wait = 0, resp_wait = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 64'hF0E0_D0C0_B0A0_9080;
            32'h0000_1008: return 64'h7766_5544_3322_1181;
            32'hFFFF_FFF8: return 64'h0123_4567_89AB_CDEF;
            32'h0000_0000: return 64'h1122_3344_5566_7788;
            default:       return {a, ~a};
        endcase
    endfunction

    // Bus responder: decides ar_ready / r_valid at each falling edge.
    int          ar_cnt = 0, r_cnt = 0;
    logic [31:0] ar_first;
    initial begin
        bus_ar_ready = 1'b0;
        bus_r_valid  = 1'b0;
        bus_r_data   = '0;
        bus_r_err    = 1'b0;
        forever begin
            @(negedge clk);
            bus_r_valid = 1'b0;
            bus_r_err   = 1'b0;
            if (rst) begin
                pend.delete();
                ar_cnt = 0;
                r_cnt = 0;
                bus_ar_ready = 1'b0;
                continue;
            end
            if (bus_ar_valid) begin
                if (ar_cnt == 0) ar_first = bus_ar_addr;
                else chk("ar_addr_stable", bus_ar_addr, ar_first);
                if (ar_cnt < ar_wait) begin
                    bus_ar_ready = 1'b0;
                    ar_cnt++;
                end else begin
                    bus_ar_ready = 1'b1;
                    ar_cnt = 0;
                    ar_log.push_back(bus_ar_addr);
                    pend.push_back(bus_ar_addr);
                end
            end else begin
                bus_ar_ready = 1'b0;
            end
            if (bus_r_ready && pend.size() > 0) begin
                if (r_cnt < r_wait) begin
                    r_cnt++;
                end else begin
                    logic [31:0] a;
                    a = pend.pop_front();
                    bus_r_valid = 1'b1;
                    bus_r_data  = mem_read(a);
                    bus_r_err   = err_en && (a == err_addr);
                    r_cnt = 0;
                end
            end
        end
    end

    // Response checker: owns resp_ready, pops the scoreboard on each handshake.
    int          w_cnt = 0;
    logic [63:0] first_data;
    logic        first_err;
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            resp_ready = 1'b0;
            if (rst || !resp_valid) begin
                w_cnt = 0;
                continue;
            end
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {63'b0, resp_valid}, 64'd0);
                resp_ready = 1'b1;
                continue;
            end
            if (w_cnt == 0) begin
                first_data = resp_data;
                first_err  = resp_err;
                if (exp_q[0].lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
            end else begin
                chk("resp_data_stable", resp_data, first_data);
                chk("resp_err_stable", {63'b0, resp_err}, {63'b0, first_err});
            end
            if (w_cnt < resp_wait) begin
                w_cnt++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_err", {63'b0, resp_err}, {63'b0, e.err});
                resp_ready = 1'b1;
                w_cnt = 0;
            end
        end
    end

    task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                            input logic [63:0] data, input logic err, input int lat);
        int   n;
        logic busy_ok;
        @(negedge clk);
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        ar_log.delete();
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_sign  = sign;
        exp_q.push_back('{data, err, lat});
        acc_cyc = cyc;
        @(negedge clk);
        // Scramble request fields: only the accepted values may matter.
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_size  = ~size;
        req_sign  = ~sign;
        busy_ok = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            if (req_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("resp_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("req_ready_busy", {63'b0, busy_ok}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_sign = 1'b0;
        req_valid32 = 1'b0; req_addr32 = '0; req_size32 = '0; req_sign32 = 1'b0;
        resp_ready32 = 1'b0;

        //             addr          sz    sg    een   eaddr         data                    err lat nar ar0           ar1
        vecs.push_back('{32'h1003, 2'd0, 1'b1, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFB0, 1'b0, 3, 1, 32'h1000, 32'h0});
        vecs.push_back('{32'h1003, 2'd0, 1'b0, 1'b0, 32'h0, 64'h0000_0000_0000_00B0, 1'b0, 3, 1, 32'h1000, 32'h0});
        vecs.push_back('{32'h1002, 2'd1, 1'b0, 1'b0, 32'h0, 64'h0000_0000_0000_B0A0, 1'b0, 3, 1, 32'h1000, 32'h0});
        vecs.push_back('{32'h100E, 2'd1, 1'b1, 1'b0, 32'h0, 64'h0000_0000_0000_7766, 1'b0, 3, 1, 32'h1008, 32'h0});
        vecs.push_back('{32'h100C, 2'd2, 1'b1, 1'b0, 32'h0, 64'h0000_0000_7766_5544, 1'b0, 3, 1, 32'h1008, 32'h0});
        vecs.push_back('{32'h1000, 2'd3, 1'b1, 1'b0, 32'h0, 64'hF0E0_D0C0_B0A0_9080, 1'b0, 3, 1, 32'h1000, 32'h0});
        vecs.push_back('{32'h1007, 2'd1, 1'b1, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_81F0, 1'b0, 5, 2, 32'h1000, 32'h1008});
        vecs.push_back('{32'h1004, 2'd3, 1'b1, 1'b0, 32'h0, 64'h3322_1181_F0E0_D0C0, 1'b0, 5, 2, 32'h1000, 32'h1008});
        vecs.push_back('{32'h1006, 2'd2, 1'b0, 1'b0, 32'h0, 64'h0000_0000_1181_F0E0, 1'b0, 5, 2, 32'h1000, 32'h1008});
        vecs.push_back('{32'h1005, 2'd2, 1'b1, 1'b0, 32'h0, 64'hFFFF_FFFF_81F0_E0D0, 1'b0, 5, 2, 32'h1000, 32'h1008});
        vecs.push_back('{32'h1004, 2'd3, 1'b1, 1'b1, 32'h1000, 64'h0, 1'b1, 3, 1, 32'h1000, 32'h0});
        vecs.push_back('{32'h1004, 2'd3, 1'b1, 1'b1, 32'h1008, 64'h0, 1'b1, 5, 2, 32'h1000, 32'h1008});
        vecs.push_back('{32'hFFFF_FFFC, 2'd3, 1'b1, 1'b0, 32'h0, 64'h5566_7788_0123_4567, 1'b0, 5, 2,
                         32'hFFFF_FFF8, 32'h0});

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_ar_valid", {63'b0, bus_ar_valid}, 64'd0);
        chk("rst_r_ready", {63'b0, bus_r_ready}, 64'd0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            err_en   = vecs[i].err_en;
            err_addr = vecs[i].err_addr;
            run_load(vecs[i].addr, vecs[i].size, vecs[i].sign, vecs[i].data, vecs[i].err,
                     vecs[i].lat);
            chk("ar_count", 64'(ar_log.size()), 64'(vecs[i].nar));
            if (ar_log.size() >= 1) chk("ar0_addr", {32'b0, ar_log[0]}, {32'b0, vecs[i].ar0});
            if (ar_log.size() >= 2) chk("ar1_addr", {32'b0, ar_log[1]}, {32'b0, vecs[i].ar1});
        end
        err_en = 1'b0;

        // Backpressure on every channel.
        ar_wait = 3; r_wait = 2; resp_wait = 4;
        run_load(32'h1000, 2'd2, 1'b1, 64'hFFFF_FFFF_B0A0_9080, 1'b0, -1);
        chk("bp_ar_count", 64'(ar_log.size()), 64'd1);
        if (ar_log.size() >= 1) chk("bp_ar0_addr", {32'b0, ar_log[0]}, 64'h1000);
        ar_wait = 0; r_wait = 0; resp_wait = 0;

        // Reset while waiting for the first beat.
        r_wait = 5;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1004; req_size = 2'd3; req_sign = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !bus_r_ready; k++) @(negedge clk);
        chk("reached_r0", {63'b0, bus_r_ready}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("mid_rst_ar_valid", {63'b0, bus_ar_valid}, 64'd0);
        chk("mid_rst_r_ready", {63'b0, bus_r_ready}, 64'd0);
        chk("mid_rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("mid_rst_resp_data", resp_data, 64'd0);
        chk("mid_rst_resp_err", {63'b0, resp_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r_wait = 0;
        run_load(32'h1001, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF90, 1'b0, 3);
        chk("post_rst_ar_count", 64'(ar_log.size()), 64'd1);

        // RV32 doubleword is illegal: error response one cycle after accept, no bus read.
        @(negedge clk);
        chk("rv32_req_ready", {63'b0, req_ready32}, 64'd1);
        req_valid32 = 1'b1; req_addr32 = 32'h1000; req_size32 = 2'd3; req_sign32 = 1'b1;
        @(negedge clk);
        req_valid32 = 1'b0;
        chk("rv32_resp_valid", {63'b0, resp_valid32}, 64'd1);
        chk("rv32_resp_err", {63'b0, resp_err32}, 64'd1);
        chk("rv32_resp_data", {32'b0, resp_data32}, 64'd0);
        chk("rv32_no_ar", {63'b0, bus_ar_valid32}, 64'd0);
        resp_ready32 = 1'b1;
        @(negedge clk);
        resp_ready32 = 1'b0;
        chk("rv32_back_idle", {63'b0, req_ready32}, 64'd1);
        chk("rv32_resp_done", {63'b0, resp_valid32}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
